// File: rtl/square_position_ctrl.sv
// -----------------------------------------------------------------------------
// square_position_ctrl
//   Converts four raw push-buttons into the top-left pixel position of a
//   movable square for the VGA display stage. Buttons are synchronised and
//   debounced; the position only moves on the frame tick so the square never
//   tears mid-frame.
//
// Ports
//   clk         in   1   pixel clock (shared with the display stage)
//   rst_n       in   1   asynchronous, active-low reset
//   frame_tick  in   1   one-cycle pulse at the start of vertical blanking
//   btn_up      in   1   raw button, active-high, asynchronous to clk
//   btn_down    in   1   raw button, active-high, asynchronous to clk
//   btn_left    in   1   raw button, active-high, asynchronous to clk
//   btn_right   in   1   raw button, active-high, asynchronous to clk
//   sq_x        out  10  square left edge, 0..H_DISPLAY-SQ_SIZE
//   sq_y        out  10  square top edge, 0..V_DISPLAY-SQ_SIZE
//   at_edge     out  4   {up,down,left,right}: square touches that border
// -----------------------------------------------------------------------------
module square_position_ctrl #(
  parameter int H_DISPLAY       = 640,
  parameter int V_DISPLAY       = 480,
  parameter int SQ_SIZE         = 20,
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int INIT_X          = 310,
  parameter int INIT_Y          = 230
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y,
  output logic [3:0] at_edge
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

  // Bound arithmetic is done on 11 bits so x+STEP can never overflow.
  localparam logic [10:0] STEP_C  = 11'(STEP);
  localparam logic [10:0] X_MAX_C = 11'(H_DISPLAY - SQ_SIZE);
  localparam logic [10:0] Y_MAX_C = 11'(V_DISPLAY - SQ_SIZE);
  localparam logic [10:0] ZERO_C  = 11'd0;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHECKING = 1'b1
  } db_state_t;

  // Bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right.
  logic [3:0] btn_raw_s;
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] deb_s;

  assign btn_raw_s = {btn_up, btn_down, btn_left, btn_right};

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    db_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             deb_bit_r;

    // Debounce FSM: a change is accepted only after the synced input has
    // disagreed with the debounced state for a full DEBOUNCE_CYCLES window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r   <= ST_STABLE;
        cnt_r     <= '0;
        deb_bit_r <= 1'b0;
      end else begin
        case (state_r)
          ST_STABLE: begin
            if (sync2_r[i] != deb_bit_r) begin
              state_r <= ST_CHECKING;
              cnt_r   <= '0;
            end else begin
              cnt_r   <= '0;
            end
          end
          ST_CHECKING: begin
            if (sync2_r[i] == deb_bit_r) begin
              // Input bounced back: discard the candidate change.
              state_r <= ST_STABLE;
              cnt_r   <= '0;
            end else if (cnt_r == CNT_LAST_C) begin
              deb_bit_r <= ~deb_bit_r;
              state_r   <= ST_STABLE;
              cnt_r     <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE_C;
            end
          end
          default: begin
            state_r <= ST_STABLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end

    assign deb_s[i] = deb_bit_r;
  end

  logic [9:0]  sq_x_r;
  logic [9:0]  sq_y_r;
  logic [3:0]  at_edge_r;
  logic [10:0] x_ext_s;
  logic [10:0] y_ext_s;
  logic [10:0] x_sum_s;
  logic [10:0] y_sum_s;
  logic [10:0] nx_s;
  logic [10:0] ny_s;

  assign x_ext_s = {1'b0, sq_x_r};
  assign y_ext_s = {1'b0, sq_y_r};
  assign x_sum_s = x_ext_s + STEP_C;
  assign y_sum_s = y_ext_s + STEP_C;

  // Candidate next position: saturating step per axis; opposing buttons cancel.
  always_comb begin
    nx_s = x_ext_s;
    ny_s = y_ext_s;

    case ({deb_s[1], deb_s[0]})
      2'b10: begin
        if (x_ext_s < STEP_C) begin
          nx_s = ZERO_C;
        end else begin
          nx_s = x_ext_s - STEP_C;
        end
      end
      2'b01: begin
        if (x_sum_s > X_MAX_C) begin
          nx_s = X_MAX_C;
        end else begin
          nx_s = x_sum_s;
        end
      end
      default: nx_s = x_ext_s;
    endcase

    case ({deb_s[3], deb_s[2]})
      2'b10: begin
        if (y_ext_s < STEP_C) begin
          ny_s = ZERO_C;
        end else begin
          ny_s = y_ext_s - STEP_C;
        end
      end
      2'b01: begin
        if (y_sum_s > Y_MAX_C) begin
          ny_s = Y_MAX_C;
        end else begin
          ny_s = y_sum_s;
        end
      end
      default: ny_s = y_ext_s;
    endcase
  end

  // Position and edge flags commit together, only on a frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_x_r    <= 10'(INIT_X);
      sq_y_r    <= 10'(INIT_Y);
      at_edge_r <= 4'b0000;
    end else if (frame_tick) begin
      sq_x_r    <= nx_s[9:0];
      sq_y_r    <= ny_s[9:0];
      at_edge_r <= {(ny_s == ZERO_C), (ny_s == Y_MAX_C),
                    (nx_s == ZERO_C), (nx_s == X_MAX_C)};
    end else begin
      sq_x_r    <= sq_x_r;
      sq_y_r    <= sq_y_r;
      at_edge_r <= at_edge_r;
    end
  end

  assign sq_x    = sq_x_r;
  assign sq_y    = sq_y_r;
  assign at_edge = at_edge_r;

endmodule

// File: tb/tb_square_position_ctrl.sv
// -----------------------------------------------------------------------------
// tb_square_position_ctrl
//   Directed scenarios followed by randomized button/tick/reset stimulus. A
//   behavioural model (raw buttons delayed two samples, a change accepted
//   after DB+1 consecutive disagreeing samples, saturating integer moves)
//   is compared with the DUT outputs on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_square_position_ctrl;

  localparam int DB   = 4;
  localparam int STEP = 4;
  localparam int XMAX = 620;
  localparam int YMAX = 460;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic [9:0] sq_x;
  logic [9:0] sq_y;
  logic [3:0] at_edge;

  int errors = 0;
  int checks = 0;

  square_position_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .sq_x       (sq_x),
    .sq_y       (sq_y),
    .at_edge    (at_edge)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_x;
  int         m_y;
  logic [3:0] m_edge;
  logic [3:0] m_h1;
  logic [3:0] m_h2;
  logic [3:0] m_deb;
  int         m_run [4];

  function automatic int move(input int p, input logic dec, input logic inc, input int maxv);
    int r;
    r = p;
    if (dec && !inc) r = p - STEP;
    if (inc && !dec) r = p + STEP;
    if (r < 0) r = 0;
    if (r > maxv) r = maxv;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x    <= 310;
      m_y    <= 230;
      m_edge <= 4'b0000;
      m_h1   <= 4'b0000;
      m_h2   <= 4'b0000;
      m_deb  <= 4'b0000;
      for (int b = 0; b < 4; b++) m_run[b] <= 0;
    end else begin
      if (frame_tick) begin
        m_x <= move(m_x, m_deb[1], m_deb[0], XMAX);
        m_y <= move(m_y, m_deb[3], m_deb[2], YMAX);
        m_edge <= {move(m_y, m_deb[3], m_deb[2], YMAX) == 0,
                   move(m_y, m_deb[3], m_deb[2], YMAX) == YMAX,
                   move(m_x, m_deb[1], m_deb[0], XMAX) == 0,
                   move(m_x, m_deb[1], m_deb[0], XMAX) == XMAX};
      end
      for (int b = 0; b < 4; b++) begin
        m_run[b] <= (m_h2[b] != m_deb[b] && m_run[b] < DB) ? m_run[b] + 1 : 0;
        m_deb[b] <= (m_h2[b] != m_deb[b] && m_run[b] == DB) ? ~m_deb[b] : m_deb[b];
      end
      m_h2 <= m_h1;
      m_h1 <= {btn_up, btn_down, btn_left, btn_right};
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    checks++;
    if (sq_x !== 10'(m_x) || sq_y !== 10'(m_y) || at_edge !== m_edge) begin
      errors++;
      $display("FAIL model t=%0t x=%0d exp %0d y=%0d exp %0d edge=%b exp %b",
               $time, sq_x, m_x, sq_y, m_y, at_edge, m_edge);
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic t);
    frame_tick = t;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    logic tk;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_x", int'(sq_x), 310);
    check_val("reset_y", int'(sq_y), 230);
    check_val("reset_edge", int'(at_edge), 0);
    rst_n = 1'b1;

    // Idle ticks: nothing moves.
    repeat (3) begin
      repeat (4) cyc(1'b0);
      cyc(1'b1);
    end
    check_val("idle_x", int'(sq_x), 310);
    check_val("idle_y", int'(sq_y), 230);
    check_val("idle_edge", int'(at_edge), 0);

    // RIGHT held, one tick.
    btn_right = 1'b1;
    repeat (10) cyc(1'b0);
    check_val("right_pre_x", int'(sq_x), 310);
    cyc(1'b1);
    check_val("right_x", int'(sq_x), 314);
    check_val("right_y", int'(sq_y), 230);
    btn_right = 1'b0;
    repeat (10) cyc(1'b0);

    // LEFT glitch rejected.
    btn_left = 1'b1;
    repeat (2) cyc(1'b0);
    btn_left = 1'b0;
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    check_val("glitch_x", int'(sq_x), 314);

    // LEFT held until saturation at 0.
    btn_left = 1'b1;
    repeat (10) cyc(1'b0);
    cyc(1'b1);
    check_val("left_first_x", int'(sq_x), 310);
    repeat (79) begin
      cyc(1'b0);
      cyc(1'b1);
    end
    check_val("left_sat_x", int'(sq_x), 0);
    check_val("left_edge", int'(at_edge[1]), 1);
    btn_left = 1'b0;
    repeat (10) cyc(1'b0);

    // DOWN held up to the lower clamp.
    btn_down = 1'b1;
    repeat (10) cyc(1'b0);
    repeat (57) begin
      cyc(1'b0);
      cyc(1'b1);
    end
    check_val("down_458_y", int'(sq_y), 458);
    check_val("down_458_edge", int'(at_edge), 4'b0010);
    cyc(1'b1);
    check_val("down_clamp_y", int'(sq_y), 460);
    check_val("down_clamp_edge", int'(at_edge), 4'b0110);
    repeat (3) cyc(1'b1);
    check_val("down_hold_y", int'(sq_y), 460);

    // UP+DOWN cancel while RIGHT moves; then async reset mid-hold.
    btn_up = 1'b1;
    btn_right = 1'b1;
    repeat (10) cyc(1'b0);
    cyc(1'b1);
    check_val("diag_y", int'(sq_y), 460);
    check_val("diag_x", int'(sq_x), 4);
    check_val("diag_edge", int'(at_edge), 4'b0100);
    repeat (3) cyc(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_x", int'(sq_x), 310);
    check_val("async_rst_y", int'(sq_y), 230);
    check_val("async_rst_edge", int'(at_edge), 0);
    @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_right = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1);
    check_val("post_rst_x", int'(sq_x), 310);

    // Randomized phase.
    repeat (3000) begin
      btn_up    = btn_up    ^ ($urandom_range(15) == 0);
      btn_down  = btn_down  ^ ($urandom_range(15) == 0);
      btn_left  = btn_left  ^ ($urandom_range(15) == 0);
      btn_right = btn_right ^ ($urandom_range(15) == 0);
      tk = ($urandom_range(7) == 0);
      if ($urandom_range(999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        cyc(tk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
